hop_lane_launch_sched: RTL and testbench

- Controller for a bank of four independent two-flop capture lanes. Each lane has its own async reset, a start input and a registered output (ffN).
- Round-robin arbitrates launch requests from four requesters. For the granted lane it sequences:
  - lane-reset assertion,
  - settle,
  - a one-cycle start pulse,
  - a latency/echo check of the lane output.
- Reports pass/fail per launch. Keeps a saturating error count.
- Sits between test/requester logic and the lane bank.

---
 rtl/hop_lane_launch_sched.sv | 179 +++++++++++++++++
 tb/tb_hop_lane_launch_sched.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hop_lane_launch_sched.sv
// Launch sequencer for a bank of four two-flop capture lanes: round-robin grant,
// lane reset, settle, one-cycle start pulse and a latency/echo check per launch.
module hop_lane_launch_sched #(
   parameter int RST_CYC    = 2,
   parameter int SETTLE_CYC = 1,
   parameter int LAT        = 2,
   parameter int ERR_W      = 8
) (
   input  logic             clock0,
   input  logic             rst1,
   input  logic [3:0]       req,
   input  logic [3:0]       lane_q,
   output logic [3:0]       lane_rst,
   output logic [3:0]       lane_start,
   output logic             busy,
   output logic             done,
   output logic [1:0]       done_lane,
   output logic             pass,
   output logic [ERR_W-1:0] err_cnt
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RST,
      S_SETTLE,
      S_FIRE,
      S_WAIT,
      S_DONE
   } state_t;

   localparam int MAX_A   = (RST_CYC > SETTLE_CYC) ? RST_CYC : SETTLE_CYC;
   localparam int MAX_CNT = (MAX_A > LAT + 1) ? MAX_A : LAT + 1;
   localparam int CNT_W   = $clog2(MAX_CNT + 1);

   localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYC - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
   localparam logic [CNT_W-1:0] ECHO_IDX    = CNT_W'(LAT);
   localparam logic [CNT_W-1:0] WAIT_LAST   = CNT_W'(LAT + 1);
   localparam logic [ERR_W-1:0] ERR_MAX     = {ERR_W{1'b1}};

   state_t           state_q;
   logic [1:0]       rr_q;
   logic [1:0]       g_q;
   logic [CNT_W-1:0] cnt_q;
   logic             fail_q;
   logic [3:0]       lane_rst_q;
   logic [3:0]       lane_start_q;
   logic             busy_q;
   logic             done_q;
   logic [1:0]       done_lane_q;
   logic             pass_q;
   logic [ERR_W-1:0] err_cnt_q;

   logic [1:0] grant_d;
   logic       grant_found;
   logic [1:0] probe_idx;
   logic       lane_bit;
   logic       echo_exp;
   logic       fail_d;

   function automatic logic [3:0] onehot(input logic [1:0] idx);
      logic [3:0] r;
      r      = '0;
      r[idx] = 1'b1;
      return r;
   endfunction

   // Round-robin search starts one past the last winner; the fourth probe
   // wraps back onto rr_q itself so a lone requester can win again.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // through the block leaves it unassigned and infers a latch.
      grant_d     = rr_q;
      grant_found = 1'b0;
      probe_idx   = rr_q;
      for (int k = 1; k <= 4; k++) begin
         probe_idx = rr_q + 2'(k);
         if (!grant_found && req[probe_idx]) begin
            grant_d     = probe_idx;
            grant_found = 1'b1;
         end
      end
   end

   assign lane_bit = lane_q[g_q];
   assign echo_exp = (cnt_q == ECHO_IDX);
   assign fail_d   = fail_q | (lane_bit ^ echo_exp);

   // NOTE: all state below is updated with non-blocking assignments so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clock0 or posedge rst1) begin
      if (rst1) begin
         state_q      <= S_IDLE;
         rr_q         <= 2'd3;
         g_q          <= 2'd0;
         cnt_q        <= '0;
         fail_q       <= 1'b0;
         lane_rst_q   <= 4'hF;
         lane_start_q <= 4'h0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         done_lane_q  <= 2'd0;
         pass_q       <= 1'b0;
         err_cnt_q    <= '0;
      end else begin
         done_q       <= 1'b0;
         lane_start_q <= 4'h0;
         case (state_q)
            S_IDLE: begin
               lane_rst_q <= 4'h0;
               if (|req) begin
                  g_q        <= grant_d;
                  rr_q       <= grant_d;
                  fail_q     <= 1'b0;
                  cnt_q      <= '0;
                  lane_rst_q <= onehot(grant_d);
                  busy_q     <= 1'b1;
                  state_q    <= S_RST;
               end
            end
            S_RST: begin
               if (cnt_q == RST_LAST) begin
                  lane_rst_q <= 4'h0;
                  cnt_q      <= '0;
                  state_q    <= S_SETTLE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_SETTLE: begin
               // A freshly reset lane must read zero before it is fired.
               fail_q <= fail_q | lane_bit;
               if (cnt_q == SETTLE_LAST) begin
                  lane_start_q <= onehot(g_q);
                  state_q      <= S_FIRE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_FIRE: begin
               cnt_q   <= CNT_W'(1);
               state_q <= S_WAIT;
            end
            S_WAIT: begin
               fail_q <= fail_d;
               if (cnt_q == WAIT_LAST) begin
                  done_q      <= 1'b1;
                  done_lane_q <= g_q;
                  pass_q      <= ~fail_d;
                  if (fail_d && (err_cnt_q != ERR_MAX)) begin
                     err_cnt_q <= err_cnt_q + 1'b1;
                  end
                  state_q <= S_DONE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_DONE: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               busy_q     <= 1'b0;
               lane_rst_q <= 4'h0;
               state_q    <= S_IDLE;
            end
         endcase
      end
   end

   assign lane_rst   = lane_rst_q;
   assign lane_start = lane_start_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign done_lane  = done_lane_q;
   assign pass       = pass_q;
   assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_hop_lane_launch_sched.sv
// Scoreboard bench for hop_lane_launch_sched: a lane-bank model drives lane_q,
// a reference model predicts grant/pass/err per launch, monitors pop and compare.
module tb_hop_lane_launch_sched;

   localparam int RST_CYC    = 2;
   localparam int SETTLE_CYC = 1;
   localparam int LAT        = 2;

   logic clock0 = 1'b0;
   logic rst1   = 1'b1;
   always #5 clock0 = ~clock0;

   logic [3:0] req = 4'h0;
   logic [3:0] lane_q, lane_rst, lane_start;
   logic       busy, done, pass;
   logic [1:0] done_lane;
   logic [7:0] err_cnt;

   logic [3:0] req2 = 4'h0;
   logic [3:0] lane_q2 = 4'h0;
   logic [3:0] lane_rst2, lane_start2;
   logic       busy2, done2, pass2;
   logic [1:0] done_lane2;
   logic [1:0] err_cnt2;

   hop_lane_launch_sched #(.RST_CYC(RST_CYC), .SETTLE_CYC(SETTLE_CYC), .LAT(LAT), .ERR_W(8)) u_dut (
      .clock0(clock0), .rst1(rst1), .req(req), .lane_q(lane_q),
      .lane_rst(lane_rst), .lane_start(lane_start), .busy(busy), .done(done),
      .done_lane(done_lane), .pass(pass), .err_cnt(err_cnt)
   );

   hop_lane_launch_sched #(.RST_CYC(RST_CYC), .SETTLE_CYC(SETTLE_CYC), .LAT(LAT), .ERR_W(2)) u_sat (
      .clock0(clock0), .rst1(rst1), .req(req2), .lane_q(lane_q2),
      .lane_rst(lane_rst2), .lane_start(lane_start2), .busy(busy2), .done(done2),
      .done_lane(done_lane2), .pass(pass2), .err_cnt(err_cnt2)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Lane bank model: mode 0 = shift chain of depth lat[i], 1 = stuck 0,
   // 2 = stuck 1, 3 = random noise.
   int         lat  [4] = '{2, 2, 2, 2};
   int         mode [4] = '{0, 0, 0, 0};
   logic [3:0] rnd = 4'h0;
   always @(negedge clock0) rnd = 4'($urandom);

   for (genvar i = 0; i < 4; i++) begin : g_lane
      logic [3:0] sh = 4'h0;
      always @(posedge clock0 or posedge lane_rst[i]) begin
         if (lane_rst[i]) sh <= 4'h0;
         else             sh <= {sh[2:0], lane_start[i]};
      end
      assign lane_q[i] = (mode[i] == 1) ? 1'b0 :
                         (mode[i] == 2) ? 1'b1 :
                         (mode[i] == 3) ? rnd[i] : sh[lat[i]-1];
   end

   // Reference model: grant, pass and error count per launch.
   typedef struct {
      logic [1:0] lane;
      logic       pass;
      logic [7:0] err;
   } exp_t;

   exp_t sb [$];
   exp_t sb2[$];
   int   m_rr   = 3;
   int   m_err  = 0;
   int   m_rr2  = 3;
   int   m_err2 = 0;

   function automatic int pick(input logic [3:0] r, input int rr);
      for (int k = 1; k <= 4; k++) begin
         if (r[(rr + k) % 4]) return (rr + k) % 4;
      end
      return 0;
   endfunction

   task automatic push_launch(input logic [3:0] r);
      exp_t e;
      int   g;
      logic p;
      g = pick(r, m_rr);
      m_rr = g;
      p = (mode[g] == 0) && (lat[g] == LAT);
      if (!p && m_err < 255) m_err++;
      e.lane = 2'(g);
      e.pass = p;
      e.err  = 8'(m_err);
      sb.push_back(e);
   endtask

   task automatic push_launch_sat(input logic [3:0] r);
      exp_t e;
      int   g;
      g = pick(r, m_rr2);
      m_rr2 = g;
      if (m_err2 < 3) m_err2++;
      e.lane = 2'(g);
      e.pass = 1'b0;
      e.err  = 8'(m_err2);
      sb2.push_back(e);
   endtask

   // Monitors
   int   cyc = 0;
   always @(posedge clock0) cyc++;

   int   n_done = 0, n_done2 = 0, done_cyc = 0;
   int   rst_cnt[4], start_cnt[4];
   int   onehot_viol = 0;
   int   gaps[$];
   int   low_run = 0;
   logic busy_prev = 1'b0;
   exp_t me, me2;

   always @(negedge clock0) begin
      if (rst1) begin
         for (int i = 0; i < 4; i++) begin
            rst_cnt[i]   = 0;
            start_cnt[i] = 0;
         end
         low_run   = 0;
         busy_prev = 1'b0;
      end else begin
         if ($countones(lane_rst | lane_start) > 1) onehot_viol++;
         for (int i = 0; i < 4; i++) begin
            rst_cnt[i]   += int'(lane_rst[i]);
            start_cnt[i] += int'(lane_start[i]);
         end
         if (busy && !busy_prev) gaps.push_back(low_run);
         low_run   = busy ? 0 : low_run + 1;
         busy_prev = busy;
         if (done) begin
            if (sb.size() == 0) begin
               check("done_without_launch", 32'(done), 0);
            end else begin
               me = sb.pop_front();
               check("done_lane", 32'(done_lane), 32'(me.lane));
               check("pass", 32'(pass), 32'(me.pass));
               check("err_cnt", 32'(err_cnt), 32'(me.err));
               check("lane_rst_cycles", rst_cnt[me.lane], RST_CYC);
               check("lane_start_cycles", start_cnt[me.lane], 1);
            end
            for (int i = 0; i < 4; i++) begin
               rst_cnt[i]   = 0;
               start_cnt[i] = 0;
            end
            n_done++;
            done_cyc = cyc;
         end
      end
   end

   always @(negedge clock0) begin
      if (!rst1 && done2) begin
         if (sb2.size() == 0) begin
            check("sat_done_without_launch", 32'(done2), 0);
         end else begin
            me2 = sb2.pop_front();
            check("sat_done_lane", 32'(done_lane2), 32'(me2.lane));
            check("sat_pass", 32'(pass2), 32'(me2.pass));
            check("sat_err_cnt", 32'(err_cnt2), 32'(me2.err));
         end
         n_done2++;
      end
   end

   // Stimulus helpers
   task automatic wait_dones(input int target, input int budget);
      int t = 0;
      while (n_done < target && t < budget) begin
         @(negedge clock0); #1;
         t++;
      end
      if (n_done < target) check("done_timeout", n_done, target);
   endtask

   task automatic wait_dones2(input int target, input int budget);
      int t = 0;
      while (n_done2 < target && t < budget) begin
         @(negedge clock0); #1;
         t++;
      end
      if (n_done2 < target) check("sat_done_timeout", n_done2, target);
   endtask

   task automatic do_reset(input logic [3:0] req_after);
      @(negedge clock0); #1;
      rst1 = 1'b1;
      req  = 4'h0;
      req2 = 4'h0;
      sb.delete();
      sb2.delete();
      m_rr = 3; m_err = 0; m_rr2 = 3; m_err2 = 0;
      #1;
      check("rst_lane_rst", 32'(lane_rst), 32'hF);
      check("rst_lane_start", 32'(lane_start), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_done_lane", 32'(done_lane), 0);
      check("rst_pass", 32'(pass), 0);
      check("rst_err_cnt", 32'(err_cnt), 0);
      check("rst_sat_err_cnt", 32'(err_cnt2), 0);
      repeat (2) @(negedge clock0);
      #1;
      rst1 = 1'b0;
      req  = req_after;
      if (req_after == 4'h0) begin
         @(negedge clock0); #1;
         check("post_rst_lane_rst", 32'(lane_rst), 0);
      end
   endtask

   int req_cyc;
   int g0;
   int t;
   int done_before;

   initial begin
      // Single launch on lane 0: latency and pulse widths.
      do_reset(4'h0);
      repeat (2) @(negedge clock0);
      #1;
      req = 4'b0001;
      req_cyc = cyc;
      push_launch(req);
      wait_dones(n_done + 1, 30);
      req = 4'h0;
      check("req_to_done_cycles", done_cyc - req_cyc, 8);

      // All four requesting: rotation order and one idle cycle between launches.
      do_reset(4'h0);
      @(negedge clock0); #1;
      req = 4'b1111;
      g0 = gaps.size();
      for (int k = 0; k < 5; k++) push_launch(req);
      wait_dones(n_done + 5, 80);
      req = 4'h0;
      for (int k = 1; k < 5; k++) begin
         if (g0 + k < gaps.size()) check("idle_gap", gaps[g0 + k], 1);
         else                      check("idle_gap_missing", gaps.size(), g0 + 5);
      end

      // Lane 2 too slow: two failing launches.
      lat[2] = 3;
      req = 4'b0100;
      push_launch(req);
      push_launch(req);
      wait_dones(n_done + 2, 40);
      req = 4'h0;
      lat[2] = 2;

      // Lane 1 stuck high, neighbours noisy.
      mode = '{3, 2, 3, 3};
      req = 4'b0010;
      push_launch(req);
      wait_dones(n_done + 1, 30);
      req = 4'h0;
      mode = '{0, 0, 0, 0};

      // Reset in the middle of a lane 3 launch.
      @(negedge clock0); #1;
      req = 4'b1000;
      push_launch(req);
      t = 0;
      while (!lane_start[3] && t < 20) begin
         @(negedge clock0); #1;
         t++;
      end
      check("lane3_fired", 32'(lane_start[3]), 1);
      @(negedge clock0); #1;
      check("busy_before_reset", 32'(busy), 1);
      done_before = n_done;
      do_reset(4'b1001);
      check("no_done_through_reset", n_done, done_before);
      push_launch(4'b1001);
      wait_dones(n_done + 1, 30);
      req = 4'h0;

      // Randomised launches with random lane latencies.
      for (int it = 0; it < 16; it++) begin
         for (int i = 0; i < 4; i++) lat[i] = ($urandom_range(0, 3) == 0) ? 3 : 2;
         req = 4'($urandom_range(1, 15));
         push_launch(req);
         wait_dones(n_done + 1, 30);
      end
      req = 4'h0;
      for (int i = 0; i < 4; i++) lat[i] = 2;

      // Narrow error counter saturates with a dead lane.
      @(negedge clock0); #1;
      req2 = 4'b0001;
      for (int k = 0; k < 5; k++) push_launch_sat(req2);
      wait_dones2(n_done2 + 5, 80);
      req2 = 4'h0;

      repeat (3) @(negedge clock0);
      check("onehot_violations", onehot_viol, 0);
      check("sb_drained", sb.size() + sb2.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
